// File: rtl/grid_scan.sv
// Row-scan driver for the 8x8 LED matrix with a tear-free double buffer.
// Optional per-row blanking is enabled by defining GRID_SCAN_BLANK_EN.
module grid_scan #(
  parameter int ROW_TICKS   = 1000,
  parameter int BLANK_TICKS = 16
) (
  input  logic        clk,
  input  logic        flopreset,
  input  logic [63:0] grid_in,
  input  logic        grid_load,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_out,
  output logic        frame_done,
  output logic        scanning
);

`ifdef GRID_SCAN_BLANK_EN
  localparam int BLANK_ON = 1;
`else
  localparam int BLANK_ON = 0;
`endif

  localparam int TOTAL = ROW_TICKS + BLANK_TICKS * BLANK_ON;
  localparam int TW    = $clog2(TOTAL);
  localparam logic [TW-1:0] LAST_TICK = TW'(TOTAL - 1);
`ifdef GRID_SCAN_BLANK_EN
  localparam logic [TW-1:0] LIT_START = TW'(BLANK_TICKS);
`endif

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state, n_state;
  logic [2:0]    row, n_row;
  logic [TW-1:0] tick, n_tick;
  logic [63:0]   shadow, n_shadow;
  logic [63:0]   pending, n_pending;
  logic          pend_v, n_pend_v;
  logic          armed;
  logic          lit;

  // Next-state view; output registers are loaded from it so they line up with the counters.
  always_comb begin
    n_state   = state;
    n_row     = row;
    n_tick    = tick;
    n_shadow  = shadow;
    n_pending = pending;
    n_pend_v  = pend_v;
    if (armed) begin
      case (state)
        IDLE: begin
          if (grid_load) begin
            n_state  = SCAN;
            n_shadow = grid_in;
            n_row    = 3'd0;
            n_tick   = '0;
          end
        end
        SCAN: begin
          if (tick == LAST_TICK) begin
            n_tick = '0;
            n_row  = row + 3'd1;
          end else begin
            n_tick = tick + TW'(1);
          end
          // A load landing exactly on the boundary skips the pending slot.
          if (row == 3'd7 && tick == LAST_TICK) begin
            if (grid_load)   n_shadow = grid_in;
            else if (pend_v) n_shadow = pending;
            n_pend_v = 1'b0;
          end else if (grid_load) begin
            n_pending = grid_in;
            n_pend_v  = 1'b1;
          end
        end
        default: n_state = IDLE;
      endcase
    end
  end

`ifdef GRID_SCAN_BLANK_EN
  assign lit = (n_state == SCAN) && (n_tick >= LIT_START);
`else
  assign lit = (n_state == SCAN);
`endif

  always_ff @(posedge clk or negedge flopreset) begin
    if (!flopreset) begin
      armed      <= 1'b0;
      state      <= IDLE;
      row        <= 3'd0;
      tick       <= '0;
      shadow     <= '0;
      pending    <= '0;
      pend_v     <= 1'b0;
      row_sel    <= 8'd0;
      col_out    <= 8'd0;
      frame_done <= 1'b0;
      scanning   <= 1'b0;
    end else begin
      // The first edge after reset release only arms the block.
      armed      <= 1'b1;
      state      <= n_state;
      row        <= n_row;
      tick       <= n_tick;
      shadow     <= n_shadow;
      pending    <= n_pending;
      pend_v     <= n_pend_v;
      row_sel    <= lit ? (8'd1 << n_row) : 8'd0;
      col_out    <= lit ? n_shadow[8*n_row +: 8] : 8'd0;
      frame_done <= (n_state == SCAN) && (n_row == 3'd7) && (n_tick == LAST_TICK);
      scanning   <= (n_state == SCAN);
    end
  end

endmodule

// File: tb/tb_grid_scan.sv
// Directed self-checking bench for grid_scan with ROW_TICKS=4, BLANK_TICKS=2.
// Define GRID_SCAN_BLANK_EN for both files to exercise the blanking build.
module tb_grid_scan;

  localparam int RT = 4;
`ifdef GRID_SCAN_BLANK_EN
  localparam int BT = 2;
`else
  localparam int BT = 0;
`endif
  localparam int PER   = RT + BT;
  localparam int FRAME = 8 * PER;

  localparam logic [63:0] DIAG = 64'h8040201008040201;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] GAA  = 64'h00000000000000AA;
  localparam logic [63:0] GSEQ = 64'h0102030405060708;

  logic        clk = 1'b0;
  logic        flopreset;
  logic [63:0] grid_in;
  logic        grid_load;
  logic [7:0]  row_sel;
  logic [7:0]  col_out;
  logic        frame_done;
  logic        scanning;

  int assert_count = 0;
  int fail_count   = 0;

  grid_scan #(.ROW_TICKS(RT), .BLANK_TICKS(2)) dut (
    .clk        (clk),
    .flopreset  (flopreset),
    .grid_in    (grid_in),
    .grid_load  (grid_load),
    .row_sel    (row_sel),
    .col_out    (col_out),
    .frame_done (frame_done),
    .scanning   (scanning)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive inputs just after an edge, then move to 1 time unit past the next edge.
  task automatic apply_stimulus(input logic load, input logic [63:0] data);
    grid_load = load;
    grid_in   = data;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_row"},  {56'd0, row_sel}, 64'd0);
    check_output({tag, "_col"},  {56'd0, col_out}, 64'd0);
    check_output({tag, "_fd"},   {63'd0, frame_done}, 64'd0);
    check_output({tag, "_scan"}, {63'd0, scanning}, 64'd0);
  endtask

  // Walk one full frame from its first cycle, checking every cycle against the grid model.
  task automatic check_frame(input logic [63:0] g, input int load_a, input logic [63:0] val_a,
                             input int load_b, input logic [63:0] val_b);
    for (int c = 1; c <= FRAME; c++) begin
      int slot;
      int r;
      logic [7:0] exp_row;
      logic [7:0] exp_col;
      slot = (c - 1) % PER;
      r    = (c - 1) / PER;
      exp_row = (slot >= BT) ? 8'(1 << r) : 8'd0;
      exp_col = (slot >= BT) ? g[8*r +: 8] : 8'd0;
      check_output($sformatf("row_sel_c%0d", c), {56'd0, row_sel}, {56'd0, exp_row});
      check_output($sformatf("col_out_c%0d", c), {56'd0, col_out}, {56'd0, exp_col});
      check_output($sformatf("frame_done_c%0d", c), {63'd0, frame_done}, {63'd0, (c == FRAME)});
      check_output($sformatf("scanning_c%0d", c), {63'd0, scanning}, 64'd1);
      if (c == load_a)      apply_stimulus(1'b1, val_a);
      else if (c == load_b) apply_stimulus(1'b1, val_b);
      else                  apply_stimulus(1'b0, 64'd0);
    end
  endtask

  initial begin
    flopreset = 1'b1;
    grid_load = 1'b0;
    grid_in   = 64'd0;
    #2 flopreset = 1'b0;
    #1 check_idle("reset_async");

    $display("[TB] reset hold with grid_load toggling");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(i[0] ? 1'b0 : 1'b1, DIAG);
      check_idle("reset_hold");
    end

    // Load held high across release: the first edge must only arm the block.
    flopreset = 1'b1;
    apply_stimulus(1'b1, DIAG);
    check_idle("release_edge");

    $display("[TB] first load of diagonal grid");
    apply_stimulus(1'b1, DIAG);
    grid_load = 1'b0;
    check_frame(DIAG, 0, 64'd0, 0, 64'd0);

    $display("[TB] tear-free update at cycle 10");
    check_frame(DIAG, 10, ALL1, 0, 64'd0);

    $display("[TB] mid-frame zero load, then boundary load of AA");
    check_frame(ALL1, 5, 64'd0, FRAME, GAA);
    check_frame(GAA, 0, 64'd0, 0, 64'd0);
    check_frame(GAA, 0, 64'd0, 0, 64'd0);

    $display("[TB] asynchronous reset during row 5");
    for (int c = 1; c < 5 * PER + BT + 1; c++) apply_stimulus(1'b0, 64'd0);
    check_output("row5_sel", {56'd0, row_sel}, 64'h20);
    check_output("row5_col", {56'd0, col_out}, 64'h00);
    #3 flopreset = 1'b0;
    #1 check_idle("midscan_async");
    apply_stimulus(1'b0, 64'd0);
    check_idle("midscan_hold");
    flopreset = 1'b1;
    apply_stimulus(1'b0, 64'd0);
    check_idle("midscan_release");
    apply_stimulus(1'b0, 64'd0);
    check_idle("midscan_idle");

    $display("[TB] restart after reset");
    apply_stimulus(1'b1, GSEQ);
    grid_load = 1'b0;
    check_frame(GSEQ, 0, 64'd0, 0, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/grid_scan.md
# grid_scan

Row-scan driver for the 8x8 LED matrix, directly downstream of the generation register. It consumes each new 64-bit grid state and holds it in a tear-free frame buffer. It then time-multiplexes the grid onto one-hot row strobes and 8 column lines, swapping buffers only at frame boundaries. It pulses `frame_done` after each complete frame so the game controller can pace evolution to the display.

## Interface
Parameters:
- `ROW_TICKS`, default 1000: clk cycles each row is lit; legal minimum 2.
- `BLANK_TICKS`, default 16: blanking cycles before each row; used only when `GRID_SCAN_BLANK_EN` is defined; legal minimum 1.

Ports:
- `clk`  input  1  system clock, rising edge.
- `flopreset`  input  1  asynchronous, active-low reset (0 = reset).
- `grid_in`  input  64  grid state; row r = `grid_in[8r+7:8r]`, column c of row r = bit 8r+c.
- `grid_load`  input  1  one-cycle strobe; `grid_in` is valid in the same cycle.
- `row_sel`  output  8  one-hot active-high row strobe; bit r lights row r.
- `col_out`  output  8  column data for the lit row; 1 = LED on.
- `frame_done`  output  1  one-cycle pulse on the last lit cycle of row 7.
- `scanning`  output  1  high while in SCAN.

## Operation
- Storage:
  - `shadow` (64 bits) is the buffer being displayed.
  - `pending` (64 bits) plus the flag `pend_v` hold the next grid.
- FSM states: IDLE, SCAN.
- IDLE:
  - Outputs are all zero.
  - On `grid_load`, `shadow` ← `grid_in` and the FSM moves to SCAN with row 0 and tick 0.
- SCAN, outside a frame boundary:
  - `grid_load` sets `pending` ← `grid_in` and `pend_v` ← 1.
  - If several loads arrive in one frame, the last one wins. Earlier ones are silently discarded.
- SCAN, frame boundary: this is the cycle where row=7 and tick=`ROW_TICKS`-1.
  - `frame_done` = 1 in that cycle.
  - At the next edge, if `grid_load` is high in that cycle, `shadow` ← `grid_in`. A load that coincides with the boundary bypasses `pending` and takes priority.
  - Otherwise, if `pend_v` is set, `shadow` ← `pending`.
  - `pend_v` clears in both cases.
  - Row returns to 0.
- Counters:
  - The tick counter is $clog2(`ROW_TICKS`) bits and counts 0..`ROW_TICKS`-1.
  - The row counter is 3 bits and wraps 7→0.
- Lit cycles: `row_sel` = 1<<row and `col_out` = `shadow[8·row+7 : 8·row]`.
- SCAN is never exited except by reset.
- Reset (asserted at any time, including mid-row):
  - State → IDLE.
  - `shadow`, `pending`, `pend_v`, and both counters → 0.
  - All outputs → 0 immediately, without waiting for a clock edge.

## Timing
- All outputs are registered and are driven from registers only.
- Output reset values: `row_sel`=0, `col_out`=0, `frame_done`=0, `scanning`=0.
- Load latency: a `grid_load` in IDLE at edge k gives `row_sel`=8'h01, `col_out`=`grid_in[7:0]`, and `scanning`=1 in cycle k+1.
- Frame period:
  - Without the macro: 8·`ROW_TICKS` cycles.
  - With the macro: 8·(`BLANK_TICKS`+`ROW_TICKS`) cycles.
- Buffer update: a new grid loaded mid-frame becomes visible on the first row-0 cycle after the next `frame_done`. No frame ever mixes two grids.
- Reset release: the first edge after `flopreset` rises only samples inputs; it has no other effect.

## Configuration
- `GRID_SCAN_BLANK_EN` defined:
  - Each row is preceded by `BLANK_TICKS` cycles with `row_sel`=0 and `col_out`=0. This suppresses ghosting.
  - The tick counter is widened to cover `BLANK_TICKS`+`ROW_TICKS`.
  - `frame_done` still marks the last lit cycle of row 7.
- `GRID_SCAN_BLANK_EN` undefined: there is no blanking, and rows are back-to-back.

## Test plan
All scenarios use `ROW_TICKS`=4 and `BLANK_TICKS`=2.
- Reset hold:
  - Stimulus: hold `flopreset`=0 and toggle `grid_load`.
  - Required response: all outputs stay 0 and `scanning`=0.
- First load:
  - Stimulus: from IDLE, pulse `grid_load` with `grid_in`=64'h8040201008040201.
  - Required response, next cycle: `row_sel`=01, `col_out`=01.
  - Required response, 4 cycles later: `row_sel`=02, `col_out`=02.
  - Required response over the frame: 8 rows show the diagonal, and `frame_done` pulses once at cycle 32.
- Tear-free update:
  - Stimulus: at cycle 10 of a frame, load 64'hFFFF_FFFF_FFFF_FFFF.
  - Required response: rows 2–7 still show the old grid. The next row 0 shows `col_out`=FF.
- Simultaneous boundary load:
  - Stimulus: load 64'h0 mid-frame, then load 64'h00000000000000AA in the `frame_done` cycle.
  - Required response: the next row 0 shows `col_out`=AA, and `pend_v`=0.
- Mid-scan reset:
  - Stimulus: assert `flopreset` during row 5.
  - Required response: outputs go 0 asynchronously, and the block returns to IDLE.
  - Follow-up: a subsequent load restarts scanning at row 0.
- Blanking, with `GRID_SCAN_BLANK_EN` defined:
  - Required response: each row is preceded by 2 cycles of `row_sel`=0.
  - Required response: the frame period is 48 cycles, and `frame_done` falls on cycle 48.
